// File: rtl/mem_stage_ls_pkg.sv
// Shared encodings, FSM state type and bus-width macros for the MEM load/store stage.
`ifndef MEM_STAGE_LS_PKG_SV
`define MEM_STAGE_LS_PKG_SV

`define MEM_WB_BUS_W(aw, dw) (32 + 1 + (aw) + (dw))
`define MEM_ID_BUS_W(aw, dw) (2 + (aw) + (dw))
`define HILO_BUS_W(dw) (2 * (dw) + 1)

package mem_stage_ls_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LBU  = 3'd2;
  localparam logic [2:0] LOAD_LH   = 3'd3;
  localparam logic [2:0] LOAD_LHU  = 3'd4;
  localparam logic [2:0] LOAD_LW   = 3'd5;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ls_state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op >= LOAD_LB) && (op <= LOAD_LW);
  endfunction

endpackage

`endif

// File: rtl/mem_stage_ls_load_align.sv
// Little-endian load alignment: selects byte/halfword/word from a read word and extends it.
module load_align
  import mem_stage_ls_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_a,
  input  logic [2:0]        i_load_op,
  output logic [DATA_W-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by sign/zero extension; a[0] is ignored for halfwords.
  always_comb begin
    case (i_a)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_a[1] ? i_data[31:16] : i_data[15:0];
    case (i_load_op)
      LOAD_LB:  o_result = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LOAD_LBU: o_result = {{(DATA_W-8){1'b0}}, w_byte};
      LOAD_LH:  o_result = {{(DATA_W-16){w_half[15]}}, w_half};
      LOAD_LHU: o_result = {{(DATA_W-16){1'b0}}, w_half};
      default:  o_result = i_data;
    endcase
  end

endmodule

// File: rtl/mem_stage_ls.sv
// MIPS MEM stage: EX/MEM pipeline register, variable-latency load handling with
// response buffering and flush-drop, and the WB / ID / HI-LO forwarding buses.
module mem_stage_ls
  import mem_stage_ls_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = 5,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [STALL_W-1:0]                     stall,
  input  logic                                   ex_valid,
  input  logic [31:0]                            ex_pc,
  input  logic                                   ex_rf_we,
  input  logic [RF_AW-1:0]                       ex_rf_waddr,
  input  logic [DATA_W-1:0]                      ex_result,
  input  logic [2:0]                             ex_load_op,
  input  logic [`HILO_BUS_W(DATA_W)-1:0]         ex_hilo,
  input  logic [DATA_W-1:0]                      data_rdata,
  input  logic                                   data_rvalid,
  output logic                                   stallreq_mem,
  output logic [`MEM_WB_BUS_W(RF_AW, DATA_W)-1:0] mem_to_wb_bus,
  output logic [`MEM_ID_BUS_W(RF_AW, DATA_W)-1:0] mem_to_id_bus,
  output logic [`HILO_BUS_W(DATA_W)-1:0]         mem_to_wb_hilo,
  output logic [`HILO_BUS_W(DATA_W)-1:0]         mem_to_ex_hilo
);

  ls_state_e                       r_state;
  ls_state_e                       w_state_nxt;
  logic                            r_valid;
  logic [31:0]                     r_pc;
  logic                            r_rf_we;
  logic [RF_AW-1:0]                r_rf_waddr;
  logic [DATA_W-1:0]               r_result;
  logic [2:0]                      r_load_op;
  logic [`HILO_BUS_W(DATA_W)-1:0]  r_hilo;
  logic [DATA_W-1:0]               r_rbuf;
  logic                            r_drop;

  logic              w_rdata_ok;
  logic              w_hold_self;
  logic              w_bubble;
  logic              w_capture;
  logic              w_advance;
  logic              w_new_load;
  logic              w_rf_we;
  logic              w_pending;
  logic [DATA_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_stall;

  assign w_unused_stall = ^stall;

  // The stage holds itself while its own load is unanswered, so the load survives
  // the controller's stall of stages 0..STAGE_IDX (which would otherwise bubble it).
  assign w_rdata_ok   = (r_state == ST_WAIT) && data_rvalid && !r_drop;
  assign w_hold_self  = (r_state == ST_WAIT) && !w_rdata_ok;
  assign stallreq_mem = w_hold_self;
  assign w_bubble     = flush || (!w_hold_self && (stall[STAGE_IDX] == STOP)
                                  && (stall[STAGE_IDX+1] == NOSTOP));
  assign w_capture    = !flush && !w_hold_self && (stall[STAGE_IDX] == NOSTOP);
  assign w_advance    = w_bubble || w_capture;
  assign w_new_load   = w_capture && ex_valid && is_load(ex_load_op);

  load_align #(.DATA_W(DATA_W)) u_align (
    .i_data    (data_rdata),
    .i_a       (r_result[1:0]),
    .i_load_op (r_load_op),
    .o_result  (w_aligned)
  );

  // EX/MEM pipeline register including HI/LO.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= 32'd0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_result   <= '0;
      r_load_op  <= LOAD_NONE;
      r_hilo     <= '0;
    end else if (w_capture) begin
      r_valid    <= ex_valid;
      r_pc       <= ex_pc;
      r_rf_we    <= ex_rf_we;
      r_rf_waddr <= ex_rf_waddr;
      r_result   <= ex_result;
      r_load_op  <= ex_load_op;
      r_hilo     <= ex_hilo;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load FSM next state; leaving WAIT/DONE may directly enter WAIT for a back-to-back load.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_new_load ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_rdata_ok) begin
          w_state_nxt = ST_WAIT;
        end else if (!w_advance) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = w_new_load ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = !w_advance ? ST_DONE : (w_new_load ? ST_WAIT : ST_IDLE);
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response buffer and drop flag; a flushed load still owes one response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbuf <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_rdata_ok && !flush) begin
        r_rbuf <= w_aligned;
      end
      if ((r_state == ST_WAIT) && flush) begin
        r_drop <= r_drop || !data_rvalid;
      end else if (r_drop && data_rvalid) begin
        r_drop <= 1'b0;
      end
    end
  end

  // Write-back data source selection.
  always_comb begin
    w_wdata = r_result;
    case (r_state)
      ST_WAIT: w_wdata = w_rdata_ok ? w_aligned : '0;
      ST_DONE: w_wdata = r_rbuf;
      default: w_wdata = r_result;
    endcase
  end

  assign w_rf_we        = r_valid && r_rf_we;
  assign w_pending      = (r_state == ST_WAIT);
  assign mem_to_wb_bus  = {r_pc, w_rf_we, r_rf_waddr, w_wdata};
  assign mem_to_id_bus  = {w_pending, w_rf_we, r_rf_waddr, w_wdata};
  assign mem_to_wb_hilo = r_hilo;
  assign mem_to_ex_hilo = r_hilo;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed test-plan scenarios followed by a randomized instruction stream checked
// against a transaction-level model of the MEM stage.
module tb_mem_stage_ls;
  import mem_stage_ls_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [SW-1:0]     stall;
  logic [SW-1:0]     ext_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic              ex_rf_we;
  logic [AW-1:0]     ex_rf_waddr;
  logic [DW-1:0]     ex_result;
  logic [2:0]        ex_load_op;
  logic [2*DW:0]     ex_hilo;
  logic [DW-1:0]     data_rdata;
  logic              data_rvalid;
  logic              stallreq_mem;
  logic [32+1+AW+DW-1:0] wb_bus;
  logic [2+AW+DW-1:0]    id_bus;
  logic [2*DW:0]     wb_hilo;
  logic [2*DW:0]     ex_hilo_fw;

  int n_tests = 0;
  int n_fail  = 0;

  // next instruction for EX and the one currently expected in MEM
  logic        nx_we, m_we;
  logic [31:0] nx_pc, m_pc, nx_res, m_res, d;
  logic [4:0]  nx_wa, m_wa;
  logic [2:0]  nx_op, m_op;
  logic [64:0] nx_hl, m_hl;
  int          lat;

  always #5 clk = ~clk;

  // simple hazard controller: a waiting load stalls stages 0..3
  assign stall = ext_stall | (stallreq_mem ? 6'b001111 : 6'b000000);

  mem_stage_ls dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .ex_load_op(ex_load_op), .ex_hilo(ex_hilo),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .stallreq_mem(stallreq_mem),
    .mem_to_wb_bus(wb_bus), .mem_to_id_bus(id_bus),
    .mem_to_wb_hilo(wb_hilo), .mem_to_ex_hilo(ex_hilo_fw)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] dat, input logic [31:0] addr,
                                           input logic [2:0] op);
    logic [31:0] v;
    int sh_b;
    int sh_h;
    sh_b = 8 * int'(addr % 32'd4);
    sh_h = 16 * int'((addr % 32'd4) / 32'd2);
    case (op)
      3'd1, 3'd2: begin
        v = (dat >> sh_b) & 32'hFF;
        if (op == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (dat >> sh_h) & 32'hFFFF;
        if (op == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'd5:    v = dat;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] wa, input logic [31:0] res,
                          input logic [2:0] op, input logic [64:0] hl);
    ex_valid = v; ex_pc = pc; ex_rf_we = we; ex_rf_waddr = wa;
    ex_result = res; ex_load_op = op; ex_hilo = hl;
  endtask

  task automatic drive_bubble();
    drive_ex(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 65'd0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd, input logic pend,
                            input logic sreq, input logic [64:0] hl);
    @(negedge clk);
    chk({tag, ".wb"}, wb_bus, {pc, we, wa, wd});
    chk({tag, ".id"}, id_bus, {pend, we, wa, wd});
    chk({tag, ".stallreq"}, stallreq_mem, sreq);
    chk({tag, ".hilo"}, wb_hilo, hl);
    chk({tag, ".exhilo"}, ex_hilo_fw, hl);
  endtask

  task automatic gen_next();
    nx_pc  = $urandom;
    nx_we  = 1'($urandom_range(0, 1));
    nx_wa  = 5'($urandom_range(0, 31));
    nx_res = $urandom;
    nx_op  = 3'($urandom_range(0, 7));
    nx_hl  = {1'($urandom_range(0, 1)), $urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ext_stall = 6'd0;
    data_rvalid = 1'b0; data_rdata = 32'd0;
    drive_bubble();
    tick(); tick();
    expect_out("reset", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0);
    rst = 1'b0;

    // LB, byte 3, zero-wait response
    drive_ex(1'b1, 32'h100, 1'b1, 5'd5, 32'h1003, LOAD_LB, 65'd0); tick();
    drive_bubble(); data_rvalid = 1'b1; data_rdata = 32'h80FF_1234;
    expect_out("lb_zero_wait", 32'h100, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b1, 1'b0, 65'd0); tick();
    data_rvalid = 1'b0;
    expect_out("lb_next_bubble", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0);

    // LHU, halfword 1, three wait cycles, ALU instruction held in EX meanwhile
    drive_ex(1'b1, 32'h104, 1'b1, 5'd6, 32'h2002, LOAD_LHU, 65'd0); tick();
    drive_ex(1'b1, 32'h108, 1'b1, 5'd7, 32'h1234_5678, LOAD_NONE, {1'b1, 32'hAAAA_0001, 32'h5555_0002});
    for (int k = 0; k < 3; k++) begin
      data_rdata = 32'hDEAD_DEAD;
      expect_out("lhu_wait", 32'h104, 1'b1, 5'd6, 32'd0, 1'b1, 1'b1, 65'd0); tick();
    end
    data_rvalid = 1'b1; data_rdata = 32'hBEEF_0011;
    expect_out("lhu_data", 32'h104, 1'b1, 5'd6, 32'h0000_BEEF, 1'b1, 1'b0, 65'd0); tick();
    data_rvalid = 1'b0;
    expect_out("alu_after_lhu", 32'h108, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 1'b0,
               {1'b1, 32'hAAAA_0001, 32'h5555_0002});

    // LW completing while WB is held: data parks in the buffer
    drive_ex(1'b1, 32'h10C, 1'b1, 5'd8, 32'h3000, LOAD_LW, 65'd0); tick();
    drive_bubble(); ext_stall = 6'b011111; data_rvalid = 1'b1; data_rdata = 32'hCAFE_F00D;
    expect_out("lw_bypass", 32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D, 1'b1, 1'b0, 65'd0); tick();
    data_rvalid = 1'b0; data_rdata = 32'hDEAD_DEAD;
    expect_out("lw_done1", 32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D, 1'b0, 1'b0, 65'd0); tick();
    expect_out("lw_done2", 32'h10C, 1'b1, 5'd8, 32'hCAFE_F00D, 1'b0, 1'b0, 65'd0);
    ext_stall = 6'd0; tick();
    expect_out("lw_released", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0);

    // flush during WAIT, then a new LB whose first strobe must be dropped
    drive_ex(1'b1, 32'h110, 1'b1, 5'd9, 32'h4000, LOAD_LB, 65'd0); tick();
    drive_bubble();
    expect_out("flush_pre", 32'h110, 1'b1, 5'd9, 32'd0, 1'b1, 1'b1, 65'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    drive_ex(1'b1, 32'h114, 1'b1, 5'd10, 32'h5000, LOAD_LB, 65'd0);
    expect_out("flush_bubble", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0); tick();
    drive_bubble(); data_rvalid = 1'b1; data_rdata = 32'h0000_0011;
    expect_out("drop_first", 32'h114, 1'b1, 5'd10, 32'd0, 1'b1, 1'b1, 65'd0); tick();
    data_rvalid = 1'b0;
    expect_out("drop_gap", 32'h114, 1'b1, 5'd10, 32'd0, 1'b1, 1'b1, 65'd0); tick();
    data_rvalid = 1'b1; data_rdata = 32'h0000_0022;
    expect_out("use_second", 32'h114, 1'b1, 5'd10, 32'h0000_0022, 1'b1, 1'b0, 65'd0); tick();
    data_rvalid = 1'b0;

    // stall[3]=1, stall[4]=0: bubble into MEM, instruction re-captured afterwards
    drive_ex(1'b1, 32'h118, 1'b1, 5'd11, 32'hA5A5, LOAD_NONE, {1'b1, 32'h1111_1111, 32'h2222_2222}); tick();
    drive_ex(1'b1, 32'h11C, 1'b1, 5'd12, 32'h5A5A, LOAD_NONE, {1'b1, 32'h3333_3333, 32'h4444_4444});
    ext_stall = 6'b001111;
    expect_out("alu_a", 32'h118, 1'b1, 5'd11, 32'hA5A5, 1'b0, 1'b0, {1'b1, 32'h1111_1111, 32'h2222_2222}); tick();
    ext_stall = 6'd0;
    expect_out("stall_bubble", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0); tick();
    drive_ex(1'b1, 32'h120, 1'b1, 5'd13, 32'h6000, LOAD_LW, 65'd0);
    expect_out("alu_b_recaptured", 32'h11C, 1'b1, 5'd12, 32'h5A5A, 1'b0, 1'b0, {1'b1, 32'h3333_3333, 32'h4444_4444});

    // reset while waiting, then a late strobe that must be ignored
    tick();
    drive_bubble();
    expect_out("rst_pre", 32'h120, 1'b1, 5'd13, 32'd0, 1'b1, 1'b1, 65'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    data_rvalid = 1'b1; data_rdata = 32'h5555_5555;
    expect_out("rst_mid_wait", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0); tick();
    data_rvalid = 1'b0;
    expect_out("rst_late_strobe", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0);

    // randomized stream: random ops (6,7 behave as non-loads), random load latency 0..3
    gen_next();
    drive_ex(1'b1, nx_pc, nx_we, nx_wa, nx_res, nx_op, nx_hl); tick();
    for (int i = 0; i < 40; i++) begin
      m_pc = nx_pc; m_we = nx_we; m_wa = nx_wa; m_res = nx_res; m_op = nx_op; m_hl = nx_hl;
      if (i < 39) begin
        gen_next();
        drive_ex(1'b1, nx_pc, nx_we, nx_wa, nx_res, nx_op, nx_hl);
      end else begin
        drive_bubble();
      end
      if (m_op >= 3'd1 && m_op <= 3'd5) begin
        lat = int'($urandom_range(0, 3));
        for (int k = 0; k < lat; k++) begin
          data_rvalid = 1'b0; data_rdata = $urandom;
          expect_out("rnd_wait", m_pc, m_we, m_wa, 32'd0, 1'b1, 1'b1, m_hl); tick();
        end
        d = $urandom; data_rvalid = 1'b1; data_rdata = d;
        expect_out("rnd_load", m_pc, m_we, m_wa, ref_load(d, m_res, m_op), 1'b1, 1'b0, m_hl); tick();
        data_rvalid = 1'b0;
      end else begin
        expect_out("rnd_alu", m_pc, m_we, m_wa, m_res, 1'b0, 1'b0, m_hl); tick();
      end
    end
    expect_out("rnd_end_bubble", 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 65'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
